sdram_responder: RTL and testbench
==================================

Name: sdram_responder

Overview:
- Synthesizable SDRAM-side responder: decodes the MT48LC16M16-style command bus produced by the core's SDRAM controller and answers from an internal block-RAM array.
- Lets the SAM Coupe core run, and lets benches close the loop, without external SDRAM.
- Also checks protocol rules: bank state, init sequence, refresh preconditions. Reports violations on sticky error flags.
- DQ is split into in/out/oe. Board-level tristate is outside this block.

Parameters:
- MEM_AW, 14, word-address width of backing RAM (2^MEM_AW x 16 bit). Linear address {BA,row,col} is truncated to its low MEM_AW bits.
- MODE_RST, 10'h220, mode-register value at reset (CL=2, BL=1, write burst disabled).

Ports:
- clk  in  1  system clock, same edge as the controller.
- init  in  1  synchronous active-high reset.
- sd_ncs  in  1  chip select, active-low.
- sd_nras  in  1  row address strobe.
- sd_ncas  in  1  column address strobe.
- sd_nwe  in  1  write enable.
- sd_cke  in  1  clock enable. When 0, the cycle is ignored (no command, burst counters hold).
- sd_a  in  13  multiplexed address.
- sd_ba  in  2  bank address.
- sd_dqml  in  1  low-byte mask.
- sd_dqmh  in  1  high-byte mask.
- sd_dq_in  in  16  write data.
- sd_dq_out  out  16  read data.
- sd_dq_oe  out  1  read-data drive enable.
- ready  out  1  LOAD_MODE seen after startup; responder accepts accesses.
- err_closed  out  1  sticky: READ/WRITE to a bank with no open row.
- err_open  out  1  sticky: ACTIVE to a bank already open.
- err_refresh  out  1  sticky: AUTO_REFRESH while any bank is open.
- refresh_cnt  out  16  AUTO_REFRESH commands counted since reset; wraps.

Behaviour:
- Reset (init=1 at clk edge):
  - All outputs go to 0, banks closed, mode=MODE_RST, any burst aborted.
  - RAM contents are kept.
  - Reset wins over any same-cycle command.
- Command decode at rising clk when sd_cke=1 and sd_ncs=0, on {nRAS,nCAS,nWE}:
  - 111 NOP
  - 011 ACTIVE
  - 101 READ
  - 100 WRITE
  - 110 BURST_TERMINATE
  - 010 PRECHARGE
  - 001 AUTO_REFRESH
  - 000 LOAD_MODE
- sd_ncs=1 is treated as NOP.
- Bank model: per bank an open flag and a 13-bit row.
  - ACTIVE sets open and latches sd_a. If the bank is already open: set err_open, then reopen with the new row.
  - PRECHARGE: sd_a[10]=1 closes all banks; otherwise closes bank sd_ba.
- LOAD_MODE:
  - mode <= sd_a[9:0]. CL = mode[6:4]; only 2 and 3 are legal, other values are treated as 3. BL = 1<<mode[2:0] for 0..3, else 1. Write-burst disable = mode[9].
  - ready <= 1.
  - Accesses before ready are still served, for bench convenience.
- Address:
  - col = sd_a[8:0]. Word address = {sd_ba, row[sd_ba], col}[MEM_AW-1:0].
  - Burst beats increment col modulo BL inside the BL-aligned block (sequential wrap).
- READ at edge k:
  - If the bank is closed: set err_closed and return no data (sd_dq_oe stays 0).
  - Otherwise beat i appears on sd_dq_out with sd_dq_oe=1, registered at edge k+CL-1+i, so the controller samples it at edge k+CL+i.
  - DQM sampled at the command edge of each beat slot masks that beat: sd_dq_oe=0 when both masks are 1. A single mask only zeroes the corresponding byte lane.
  - Column auto-precharge (sd_a[10]=1) closes the bank after the last beat.
- WRITE at edge k:
  - If the bank is closed: set err_closed and do not write.
  - Otherwise beat 0 writes sd_dq_in at edge k. Byte enables are ~dqml (low byte) and ~dqmh (high byte).
  - If write-burst is enabled and BL>1, beats 1..BL-1 are taken on edges k+1.. with per-edge DQM.
  - sd_dq_oe is forced 0 from the WRITE edge on.
- Read-after-write to the same word returns the new data. The RAM write is done before the read pipeline stage; no bypass is needed given CL>=2.
- Interrupts:
  - A new READ/WRITE, BURST_TERMINATE, or PRECHARGE to the bursting bank ends the current burst after beats already in the CL pipeline.
  - A new READ restarts the burst.
- AUTO_REFRESH: refresh_cnt++. If any bank is open, set err_refresh.
- Error flags clear only on init.

Test Plan:
- Init, then LOAD_MODE sd_a=10'h220, ACTIVE BA=1 row=5, WRITE col=3 data 16'hA55A, READ col=3 → ready=1; sd_dq_oe=1 and sd_dq_out=16'hA55A sampled exactly 2 edges after READ; no errors.
- LOAD_MODE CL=3 BL=4, WRITE words 0x11..0x44 to cols 4..7, READ col=6 → samples at edges +3..+6 read 0x33,0x44,0x11,0x22 (wrap).
- WRITE 16'hFFFF, then WRITE 16'h1234 with dqmh=1, READ → 16'hFF34. READ with dqml=dqmh=1 → sd_dq_oe stays 0.
- READ to a closed bank, ACTIVE twice on bank 2, AUTO_REFRESH with bank 0 open → err_closed, err_open, err_refresh each 1 and sticky. Pulse init → all 0.
- PRECHARGE all, 3× AUTO_REFRESH → refresh_cnt=3, err_refresh=0. Same with sd_cke=0 → count unchanged.
- Assert init in the middle of a BL=8 read at beat 2 → sd_dq_oe=0 from the next edge; mode returns to CL=2 BL=1; previously written data is still readable after re-ACTIVE.

Source files
------------

// File: rtl/sdram_responder_if.sv
// SDRAM command/data bus between a controller (master) and the responder (slave).
// DQ is split into in/out/oe; the board-level tristate lives outside.
interface sdram_responder_if;
    logic        sd_ncs;
    logic        sd_nras;
    logic        sd_ncas;
    logic        sd_nwe;
    logic        sd_cke;
    logic [12:0] sd_a;
    logic [1:0]  sd_ba;
    logic        sd_dqml;
    logic        sd_dqmh;
    logic [15:0] sd_dq_in;
    logic [15:0] sd_dq_out;
    logic        sd_dq_oe;

    modport master (
        output sd_ncs, sd_nras, sd_ncas, sd_nwe, sd_cke, sd_a, sd_ba,
               sd_dqml, sd_dqmh, sd_dq_in,
        input  sd_dq_out, sd_dq_oe
    );

    modport slave (
        input  sd_ncs, sd_nras, sd_ncas, sd_nwe, sd_cke, sd_a, sd_ba,
               sd_dqml, sd_dqmh, sd_dq_in,
        output sd_dq_out, sd_dq_oe
    );
endinterface

// File: rtl/sdram_responder.sv
// SDRAM-side responder: decodes the controller's command bus, answers from on-chip RAM
// at the programmed CAS latency and burst length, and flags bank/refresh protocol errors.
module sdram_responder #(
    parameter int         MEM_AW   = 14,
    parameter logic [9:0] MODE_RST = 10'h220
) (
    input  logic             clk,
    input  logic             init,
    sdram_responder_if.slave sd,
    output logic             ready,
    output logic             err_closed,
    output logic             err_open,
    output logic             err_refresh,
    output logic [15:0]      refresh_cnt
);
    localparam int STAGES = 1;

    typedef enum logic [2:0] {
        CMD_LMR = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_ACT = 3'b011,
        CMD_WR  = 3'b100,
        CMD_RD  = 3'b101,
        CMD_BST = 3'b110,
        CMD_NOP = 3'b111
    } cmd_t;

    typedef struct packed {
        logic [MEM_AW-1:0] addr;
        logic              dqml;
        logic              dqmh;
    } beat_t;

    // Burst length as a column wrap mask; reserved encodings fall back to BL=1.
    function automatic logic [2:0] bl_mask_of(input logic [2:0] bl);
        case (bl)
            3'd1:    return 3'd1;
            3'd2:    return 3'd3;
            3'd3:    return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic cl3_of(input logic [2:0] cl);
        return cl != 3'd2;
    endfunction

    function automatic logic [MEM_AW-1:0] waddr(input logic [1:0] ba, input logic [12:0] row,
                                                input logic [8:0] col);
        return MEM_AW'({ba, row, col});
    endfunction

    function automatic logic [8:0] beat_col(input logic [8:0] col, input logic [2:0] msk,
                                            input logic [2:0] idx);
        return (col & ~{6'd0, msk}) | ((col + {6'd0, idx}) & {6'd0, msk});
    endfunction

    logic [15:0] mem [0:(1<<MEM_AW)-1];

    logic [3:0]        bank_open;
    logic [3:0][12:0]  bank_row;
    logic              mode_cl3;
    logic [2:0]        mode_bl;
    logic              mode_wb_en;

    logic              bst_act;
    logic              bst_wr;
    logic              bst_ap;
    logic [1:0]        bst_bank;
    logic [12:0]       bst_row;
    logic [8:0]        bst_col;
    logic [2:0]        bst_cnt;
    logic [2:0]        bst_mask;

    logic [STAGES:0]   vld_pipe;
    beat_t [STAGES:0]  beat_pipe;
    logic              oe_q;
    logic              lane_lo;
    logic              lane_hi;
    logic [15:0]       rd_data;

    cmd_t              cmd;
    logic              brk;
    logic              beat_go;
    logic              new_rd;
    logic              issue_vld;
    beat_t             issue;
    beat_t             out_beat;
    logic              out_vld;
    logic              we;
    logic [1:0]        wbe;
    logic [MEM_AW-1:0] wa;
    logic [MEM_AW-1:0] bst_addr;

    always_comb begin
        cmd = CMD_NOP;
        if (sd.sd_cke && !sd.sd_ncs)
            cmd = cmd_t'({sd.sd_nras, sd.sd_ncas, sd.sd_nwe});
    end

    // Any new access, a burst stop, or a precharge hitting the bursting bank ends the burst.
    always_comb begin
        brk      = (cmd == CMD_RD) || (cmd == CMD_WR) || (cmd == CMD_BST) ||
                   ((cmd == CMD_PRE) && (sd.sd_a[10] || (sd.sd_ba == bst_bank)));
        beat_go  = bst_act && sd.sd_cke && !brk;
        bst_addr = waddr(bst_bank, bst_row, beat_col(bst_col, bst_mask, bst_cnt));
        new_rd   = (cmd == CMD_RD) && bank_open[sd.sd_ba];
    end

    always_comb begin
        issue_vld  = new_rd || (beat_go && !bst_wr);
        issue.addr = new_rd ? waddr(sd.sd_ba, bank_row[sd.sd_ba], sd.sd_a[8:0]) : bst_addr;
        issue.dqml = sd.sd_dqml;
        issue.dqmh = sd.sd_dqmh;
        out_beat   = mode_cl3 ? beat_pipe[1] : beat_pipe[0];
        out_vld    = mode_cl3 ? vld_pipe[1] : vld_pipe[0];
    end

    always_comb begin
        we  = 1'b0;
        wa  = bst_addr;
        wbe = {~sd.sd_dqmh, ~sd.sd_dqml};
        if (!init) begin
            if ((cmd == CMD_WR) && bank_open[sd.sd_ba]) begin
                we = 1'b1;
                wa = waddr(sd.sd_ba, bank_row[sd.sd_ba], sd.sd_a[8:0]);
            end else if (beat_go && bst_wr) begin
                we = 1'b1;
            end
        end
    end

    // Backing store: no reset so contents survive init.
    always_ff @(posedge clk) begin
        if (we && wbe[0]) mem[wa][7:0]  <= sd.sd_dq_in[7:0];
        if (we && wbe[1]) mem[wa][15:8] <= sd.sd_dq_in[15:8];
        rd_data <= mem[out_beat.addr];
    end

    always_ff @(posedge clk) begin
        if (init) begin
            bank_open   <= '0;
            bank_row    <= '0;
            mode_cl3    <= cl3_of(MODE_RST[6:4]);
            mode_bl     <= bl_mask_of(MODE_RST[2:0]);
            mode_wb_en  <= !MODE_RST[9];
            ready       <= 1'b0;
            err_closed  <= 1'b0;
            err_open    <= 1'b0;
            err_refresh <= 1'b0;
            refresh_cnt <= '0;
            bst_act     <= 1'b0;
            bst_wr      <= 1'b0;
            bst_ap      <= 1'b0;
            bst_bank    <= '0;
            bst_row     <= '0;
            bst_col     <= '0;
            bst_cnt     <= '0;
            bst_mask    <= '0;
            vld_pipe    <= '0;
            beat_pipe   <= '0;
            oe_q        <= 1'b0;
            lane_lo     <= 1'b0;
            lane_hi     <= 1'b0;
        end else begin
            if ((cmd == CMD_RD) || (cmd == CMD_WR)) begin
                bst_act  <= bank_open[sd.sd_ba] && (mode_bl != 3'd0) &&
                            ((cmd == CMD_RD) || mode_wb_en);
                bst_wr   <= (cmd == CMD_WR);
                bst_ap   <= (cmd == CMD_RD) && sd.sd_a[10];
                bst_bank <= sd.sd_ba;
                bst_row  <= bank_row[sd.sd_ba];
                bst_col  <= sd.sd_a[8:0];
                bst_cnt  <= 3'd1;
                bst_mask <= mode_bl;
            end else if (brk) begin
                bst_act <= 1'b0;
            end else if (beat_go) begin
                bst_cnt <= bst_cnt + 3'd1;
                if (bst_cnt == bst_mask) begin
                    bst_act <= 1'b0;
                    if (bst_ap) bank_open[bst_bank] <= 1'b0;
                end
            end

            case (cmd)
                CMD_ACT: begin
                    if (bank_open[sd.sd_ba]) err_open <= 1'b1;
                    bank_open[sd.sd_ba] <= 1'b1;
                    bank_row[sd.sd_ba]  <= sd.sd_a;
                end
                CMD_RD, CMD_WR: begin
                    if (!bank_open[sd.sd_ba])
                        err_closed <= 1'b1;
                    else if ((cmd == CMD_RD) && sd.sd_a[10] && (mode_bl == 3'd0))
                        bank_open[sd.sd_ba] <= 1'b0;
                end
                CMD_PRE: begin
                    if (sd.sd_a[10]) bank_open <= '0;
                    else             bank_open[sd.sd_ba] <= 1'b0;
                end
                CMD_REF: begin
                    refresh_cnt <= refresh_cnt + 16'd1;
                    if (|bank_open) err_refresh <= 1'b1;
                end
                CMD_LMR: begin
                    mode_cl3   <= cl3_of(sd.sd_a[6:4]);
                    mode_bl    <= bl_mask_of(sd.sd_a[2:0]);
                    mode_wb_en <= !sd.sd_a[9];
                    ready      <= 1'b1;
                end
                default: ;
            endcase

            // A WRITE turns the bus around: drop everything still queued for output.
            beat_pipe <= {beat_pipe[STAGES-1:0], issue};
            if (cmd == CMD_WR) begin
                vld_pipe <= '0;
                oe_q     <= 1'b0;
                lane_lo  <= 1'b0;
                lane_hi  <= 1'b0;
            end else begin
                vld_pipe <= {vld_pipe[STAGES-1:0], issue_vld};
                oe_q     <= out_vld && !(out_beat.dqml && out_beat.dqmh);
                lane_lo  <= out_vld && !out_beat.dqml;
                lane_hi  <= out_vld && !out_beat.dqmh;
            end
        end
    end

    assign sd.sd_dq_oe  = oe_q;
    assign sd.sd_dq_out = {lane_hi ? rd_data[15:8] : 8'h00, lane_lo ? rd_data[7:0] : 8'h00};

endmodule

// File: tb/tb_sdram_responder.sv
// Bench for sdram_responder: directed command sequences, read data checked by a
// scoreboard monitor against expected (edge, value) pairs, status flags checked inline.
module tb_sdram_responder;
    localparam logic [2:0] LMR = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011;
    localparam logic [2:0] WR  = 3'b100, RD  = 3'b101, NOP = 3'b111;

    logic        clk = 1'b0;
    logic        init;
    logic        ready, err_closed, err_open, err_refresh;
    logic [15:0] refresh_cnt;

    sdram_responder_if bus();

    sdram_responder #(.MEM_AW(14), .MODE_RST(10'h220)) dut (
        .clk         (clk),
        .init        (init),
        .sd          (bus),
        .ready       (ready),
        .err_closed  (err_closed),
        .err_open    (err_open),
        .err_refresh (err_refresh),
        .refresh_cnt (refresh_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   k;

    always @(negedge clk) begin
        if (bus.sd_dq_oe === 1'b1) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected: oe=1 dq=%h at edge %0d, required oe=0", bus.sd_dq_out, cyc);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.data !== bus.sd_dq_out) begin
                    fails++;
                    $display("FAIL rd_data: got %h at edge %0d, required %h at edge %0d",
                             bus.sd_dq_out, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Drive one command for the next rising edge, return at the following negedge.
    task automatic cmd(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] dq, input logic ml, input logic mh);
        bus.sd_ncs = 1'b0;
        {bus.sd_nras, bus.sd_ncas, bus.sd_nwe} = c;
        bus.sd_ba    = ba;
        bus.sd_a     = a;
        bus.sd_dq_in = dq;
        bus.sd_dqml  = ml;
        bus.sd_dqmh  = mh;
        @(negedge clk);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) cmd(NOP, 2'd0, 13'd0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic expect_rd(input int kk, input int cl, input int beat, input logic [15:0] d);
        exp_t x;
        x.cyc  = kk + cl - 1 + beat;
        x.data = d;
        q.push_back(x);
    endtask

    initial begin
        init = 1'b1;
        bus.sd_cke = 1'b1;
        bus.sd_ncs = 1'b1;
        {bus.sd_nras, bus.sd_ncas, bus.sd_nwe} = NOP;
        bus.sd_a = '0; bus.sd_ba = '0; bus.sd_dq_in = '0;
        bus.sd_dqml = 1'b0; bus.sd_dqmh = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_err", {err_closed, err_open, err_refresh}, 0);
        check("rst_cnt", refresh_cnt, 0);
        check("rst_oe", bus.sd_dq_oe, 0);
        init = 1'b0;

        // Basic write then CL=2 read
        cmd(LMR, 2'd0, 13'h220, 16'h0, 1'b0, 1'b0);
        cmd(ACT, 2'd1, 13'd5, 16'h0, 1'b0, 1'b0);
        cmd(WR, 2'd1, 13'd3, 16'hA55A, 1'b0, 1'b0);
        k = cyc + 1;
        cmd(RD, 2'd1, 13'd3, 16'h0, 1'b0, 1'b0);
        expect_rd(k, 2, 0, 16'hA55A);
        nop(3);
        check("t1_ready", ready, 1);
        check("t1_err", {err_closed, err_open, err_refresh}, 0);

        // CL=3 BL=4 write burst then wrapping read from col 6
        cmd(LMR, 2'd0, 13'h032, 16'h0, 1'b0, 1'b0);
        cmd(WR, 2'd1, 13'd4, 16'h0011, 1'b0, 1'b0);
        cmd(NOP, 2'd0, 13'd0, 16'h0022, 1'b0, 1'b0);
        cmd(NOP, 2'd0, 13'd0, 16'h0033, 1'b0, 1'b0);
        cmd(NOP, 2'd0, 13'd0, 16'h0044, 1'b0, 1'b0);
        k = cyc + 1;
        cmd(RD, 2'd1, 13'd6, 16'h0, 1'b0, 1'b0);
        expect_rd(k, 3, 0, 16'h0033);
        expect_rd(k, 3, 1, 16'h0044);
        expect_rd(k, 3, 2, 16'h0011);
        expect_rd(k, 3, 3, 16'h0022);
        nop(7);
        check("t2_drained", q.size(), 0);

        // Byte masks on write and read
        cmd(LMR, 2'd0, 13'h220, 16'h0, 1'b0, 1'b0);
        cmd(WR, 2'd1, 13'd10, 16'hFFFF, 1'b0, 1'b0);
        cmd(WR, 2'd1, 13'd10, 16'h1234, 1'b0, 1'b1);
        k = cyc + 1;
        cmd(RD, 2'd1, 13'd10, 16'h0, 1'b0, 1'b0);
        expect_rd(k, 2, 0, 16'hFF34);
        k = cyc + 1;
        cmd(RD, 2'd1, 13'd10, 16'h0, 1'b1, 1'b0);
        expect_rd(k, 2, 0, 16'hFF00);
        cmd(RD, 2'd1, 13'd10, 16'h0, 1'b1, 1'b1);
        nop(1);
        check("t3_masked_oe", bus.sd_dq_oe, 0);
        nop(2);

        // Protocol errors, stickiness, and clear on init
        cmd(RD, 2'd3, 13'd0, 16'h0, 1'b0, 1'b0);
        nop(2);
        check("t4_err_closed", {err_closed, err_open, err_refresh}, 3'b100);
        cmd(ACT, 2'd2, 13'd1, 16'h0, 1'b0, 1'b0);
        cmd(ACT, 2'd2, 13'd2, 16'h0, 1'b0, 1'b0);
        cmd(ACT, 2'd0, 13'd0, 16'h0, 1'b0, 1'b0);
        cmd(REF, 2'd0, 13'd0, 16'h0, 1'b0, 1'b0);
        check("t4_err_all", {err_closed, err_open, err_refresh}, 3'b111);
        check("t4_cnt", refresh_cnt, 1);
        nop(3);
        check("t4_sticky", {err_closed, err_open, err_refresh}, 3'b111);
        init = 1'b1;
        nop(1);
        init = 1'b0;
        check("t4_clr_err", {err_closed, err_open, err_refresh}, 0);
        check("t4_clr_ready", ready, 0);
        check("t4_clr_cnt", refresh_cnt, 0);

        // Refresh counting, and cke=0 suppression
        cmd(PRE, 2'd0, 13'h400, 16'h0, 1'b0, 1'b0);
        repeat (3) cmd(REF, 2'd0, 13'd0, 16'h0, 1'b0, 1'b0);
        check("t5_cnt", refresh_cnt, 3);
        check("t5_err_ref", err_refresh, 0);
        bus.sd_cke = 1'b0;
        repeat (3) cmd(REF, 2'd0, 13'd0, 16'h0, 1'b0, 1'b0);
        bus.sd_cke = 1'b1;
        nop(1);
        check("t5_cke_cnt", refresh_cnt, 3);

        // Init aborts a BL=8 read after two beats; data survives, mode is back to CL2 BL1
        cmd(LMR, 2'd0, 13'h023, 16'h0, 1'b0, 1'b0);
        cmd(ACT, 2'd0, 13'd7, 16'h0, 1'b0, 1'b0);
        cmd(WR, 2'd0, 13'd0, 16'h0100, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) cmd(NOP, 2'd0, 13'd0, 16'h0100 + 16'(i), 1'b0, 1'b0);
        k = cyc + 1;
        cmd(RD, 2'd0, 13'd0, 16'h0, 1'b0, 1'b0);
        expect_rd(k, 2, 0, 16'h0100);
        expect_rd(k, 2, 1, 16'h0101);
        nop(2);
        init = 1'b1;
        nop(1);
        check("t6_abort_oe", bus.sd_dq_oe, 0);
        init = 1'b0;
        nop(2);
        check("t6_abort_oe_hold", bus.sd_dq_oe, 0);
        check("t6_ready", ready, 0);
        cmd(ACT, 2'd0, 13'd7, 16'h0, 1'b0, 1'b0);
        k = cyc + 1;
        cmd(RD, 2'd0, 13'd2, 16'h0, 1'b0, 1'b0);
        expect_rd(k, 2, 0, 16'h0102);
        nop(5);
        check("t6_err", {err_closed, err_open, err_refresh}, 0);

        check("sb_drain", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
